// File: rtl/midi_out_tx.sv
// MIDI serial transmitter: byte FIFO feeding an 8N1 framer (start, BYTE_W data bits LSB first, stop).
// Optional running-status suppression is compiled in with `define MIDI_RUNNING_STATUS_EN.
module midi_out_tx #(
    parameter int BYTE_W     = 8,
    parameter int MIDI_BAUD  = 31250,
    parameter int SYSCLK_F   = 48000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              wr_en,
    output logic              fifo_full,
    output logic              busy,
    output logic              MIDI_OUT,
    output logic              byte_sent_strobe
);

    localparam int         CLK_PER_BIT = SYSCLK_F / MIDI_BAUD;
    localparam logic [10:0] CNT_LAST   = 11'(CLK_PER_BIT - 1);
    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam int         IW          = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(BYTE_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              empty, push, pop, suppress;
    logic [BYTE_W-1:0] head;

    assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push      = wr_en && !fifo_full;

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    // Last channel-status byte sent; zero means no running status is active.
    logic [7:0] rs_q;
    logic       is_status;

    assign is_status = head[7] && (head[6:4] != 3'b111);
    assign suppress  = is_status && (head[7:0] == rs_q);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rs_q <= '0;
        end else if (pop && !suppress) begin
            if (is_status)                 rs_q <= head[7:0];
            else if (head[7:3] == 5'b11110) rs_q <= '0;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Framer
    state_t            state_q, state_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              line_d, strobe_d, last;

    assign last = (cnt_q == CNT_LAST);
    assign busy = (state_q != IDLE) || !empty;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        strobe_d = 1'b0;
        line_d   = 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop = 1'b1;
                    if (!suppress) begin
                        state_d = START;
                        shift_d = head;
                    end
                end
            end
            START: begin
                line_d = 1'b0;
                if (last) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            DATA: begin
                line_d = shift_q[0];
                if (last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) state_d = STOP;
                    else                   idx_d = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!empty) begin
                        pop = 1'b1;
                        if (!suppress) begin
                            state_d = START;
                            shift_d = head;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            idx_q            <= '0;
            shift_q          <= '0;
            MIDI_OUT         <= 1'b1;
            byte_sent_strobe <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            shift_q          <= shift_d;
            MIDI_OUT         <= line_d;
            byte_sent_strobe <= strobe_d;
        end
    end

endmodule

// File: tb/tb_midi_out_tx.sv
// Directed bench for midi_out_tx: one instance at default timing, one with a 16-clock bit period.
module tb_midi_out_tx;

    localparam int DEF_CPB  = 1536;
    localparam int FAST_CPB = 16;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_data = '0, f_data = '0;
    logic       d_wr = 1'b0, f_wr = 1'b0;
    logic       d_full, d_busy, d_midi, d_stb;
    logic       f_full, f_busy, f_midi, f_stb;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] drv_q[$];
    logic       drv_force = 1'b0;
    logic [7:0] exp_q[$];

    always #5 sys_clk = ~sys_clk;

    midi_out_tx dut_def (
        .sys_clk(sys_clk), .rst(rst), .data_in(d_data), .wr_en(d_wr),
        .fifo_full(d_full), .busy(d_busy), .MIDI_OUT(d_midi), .byte_sent_strobe(d_stb)
    );

    midi_out_tx #(.SYSCLK_F(31250 * FAST_CPB)) dut (
        .sys_clk(sys_clk), .rst(rst), .data_in(f_data), .wr_en(f_wr),
        .fifo_full(f_full), .busy(f_busy), .MIDI_OUT(f_midi), .byte_sent_strobe(f_stb)
    );

    // Write driver for the fast instance: waits for space unless drv_force is set.
    always begin
        @(posedge sys_clk);
        #2;
        if (drv_q.size() > 0 && (drv_force || !f_full)) begin
            f_data = drv_q.pop_front();
            f_wr   = 1'b1;
        end else begin
            f_wr = 1'b0;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered at the first low sample of a frame (or k0 cycles into it); returns at the next frame slot.
    task automatic check_frame(input logic sel, input logic [7:0] val, input int cpb, input int k0,
                               input logic [8:0] inject, input string tag);
        int   bad_bits[10];
        int   bad_stb;
        int   b;
        logic exp_l, exp_s, obs_l, obs_s;
        for (int i = 0; i < 10; i++) bad_bits[i] = 0;
        bad_stb = 0;
        for (int k = k0; k < 10 * cpb; k++) begin
            b     = k / cpb;
            exp_l = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : val[b-1];
            exp_s = (k == 10 * cpb - 1);
            obs_l = sel ? f_midi : d_midi;
            obs_s = sel ? f_stb : d_stb;
            if (obs_l !== exp_l) bad_bits[b]++;
            if (obs_s !== exp_s) bad_stb++;
            if (inject[8] && k == 10 * cpb - 2) begin
                drv_force = 1'b1;
                drv_q.push_back(inject[7:0]);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) chk($sformatf("%s_bit%0d_bad_cycles", tag, i), bad_bits[i], 0);
        chk($sformatf("%s_strobe_bad_cycles", tag), bad_stb, 0);
    endtask

    task automatic idle_check(input int cycles, input string tag);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            if (f_midi !== 1'b1 || f_stb !== 1'b0) bad++;
            tick();
        end
        chk(tag, bad, 0);
    endtask

    task automatic wait_start(input string tag);
        int waited = 0;
        while (f_midi !== 1'b0 && waited < 4 * FAST_CPB) begin
            tick();
            waited++;
        end
        chk(tag, f_midi, 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_def_line", d_midi, 1);
        chk("rst_def_busy", d_busy, 0);
        chk("rst_line", f_midi, 1);
        chk("rst_strobe", f_stb, 0);
        chk("rst_full", f_full, 0);
        chk("rst_busy", f_busy, 0);
        rst = 1'b0;
        tick();

        // Default timing: 0x90 from idle, line low from edge N+2
        d_data = 8'h90;
        d_wr   = 1'b1;
        tick();
        d_wr = 1'b0;
        chk("lat_busy_n", d_busy, 1);
        chk("lat_line_n", d_midi, 1);
        tick();
        chk("lat_line_n1", d_midi, 1);
        tick();
        check_frame(1'b0, 8'h90, DEF_CPB, 0, 9'h0, "def_90");
        chk("def_busy_after", d_busy, 0);
        chk("def_line_after", d_midi, 1);

        // Burst of three bytes on consecutive clocks: back-to-back frames
        drv_q = '{8'h90, 8'h3C, 8'h7F};
        tick();
        chk("burst_line_n", f_midi, 1);
        tick();
        chk("burst_line_n1", f_midi, 1);
        chk("burst_full_n1", f_full, 0);
        tick();
        check_frame(1'b1, 8'h90, FAST_CPB, 0, 9'h0, "burst0");
        check_frame(1'b1, 8'h3C, FAST_CPB, 0, 9'h0, "burst1");
        check_frame(1'b1, 8'h7F, FAST_CPB, 0, 9'h0, "burst2");
        chk("burst_busy_after", f_busy, 0);
        idle_check(2 * FAST_CPB, "burst_idle");

        // Six writes on consecutive clocks: fifth fills the FIFO, sixth dropped;
        // a seventh arrives on the pop edge while still full and is dropped too
        drv_force = 1'b1;
        drv_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tick();
        tick();
        tick();
        chk("ovf_line_low", f_midi, 0);
        tick();
        tick();
        chk("ovf_full_set", f_full, 1);
        tick();
        chk("ovf_full_hold", f_full, 1);
        tick();
        check_frame(1'b1, 8'h11, FAST_CPB, 4, {1'b1, 8'h77}, "ovf0");
        drv_force = 1'b0;
        chk("ovf_full_after_pop", f_full, 0);
        check_frame(1'b1, 8'h22, FAST_CPB, 0, 9'h0, "ovf1");
        check_frame(1'b1, 8'h33, FAST_CPB, 0, 9'h0, "ovf2");
        check_frame(1'b1, 8'h44, FAST_CPB, 0, 9'h0, "ovf3");
        check_frame(1'b1, 8'h55, FAST_CPB, 0, 9'h0, "ovf4");
        chk("ovf_busy_after", f_busy, 0);
        idle_check(12 * FAST_CPB, "ovf_no_extra_frame");

        // Reset during data bit 3 aborts the frame and flushes the queue
        drv_q = '{8'h55, 8'hAA, 8'h0F};
        tick();
        tick();
        tick();
        chk("abort_line_low", f_midi, 0);
        repeat (4 * FAST_CPB + 5) tick();
        rst = 1'b1;
        tick();
        chk("abort_line", f_midi, 1);
        chk("abort_busy", f_busy, 0);
        chk("abort_strobe", f_stb, 0);
        chk("abort_full", f_full, 0);
        rst = 1'b0;
        idle_check(12 * FAST_CPB, "abort_no_frames");

        // Running status: repeated 0x90 suppressed only when the feature is built in
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h90, 8'h3C, 8'h7F, 8'h40, 8'h7F};
`else
        exp_q = '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F};
`endif
        drv_q = '{8'h90, 8'h3C, 8'h7F, 8'h90, 8'h40, 8'h7F};
        while (exp_q.size() > 0) begin
            wait_start("rs_a_start");
            check_frame(1'b1, exp_q.pop_front(), FAST_CPB, 0, 9'h0, "rs_a");
        end
        idle_check(12 * FAST_CPB, "rs_a_idle");

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
`ifdef MIDI_RUNNING_STATUS_EN
        exp_q = '{8'h90, 8'hF8};
`else
        exp_q = '{8'h90, 8'hF8, 8'h90};
`endif
        drv_q = '{8'h90, 8'hF8, 8'h90};
        while (exp_q.size() > 0) begin
            wait_start("rs_b_start");
            check_frame(1'b1, exp_q.pop_front(), FAST_CPB, 0, 9'h0, "rs_b");
        end
        idle_check(12 * FAST_CPB, "rs_b_idle");
        chk("rs_b_busy", f_busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/midi_out_tx.md
MIDI_OUT_TX -- requirements
Module: midi_out_tx

Interface
REQ-001 Parameter BYTE_W, default 8, data byte width.
REQ-002 Parameter MIDI_BAUD, default 31250, line bit rate in bits/s.
REQ-003 Parameter SYSCLK_F, default 48000000, sys_clk frequency in Hz.
REQ-004 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-005 sys_clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 data_in  input  BYTE_W  byte to queue for transmission.
REQ-008 wr_en  input  1  push data_in into FIFO on this edge.
REQ-009 fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-011 MIDI_OUT  output  1  serial line, idle high, 8N1.
REQ-012 byte_sent_strobe  output  1  one-cycle pulse at end of each transmitted stop bit.

Function
REQ-013 Bit period SHALL be CLK_PER_BIT = SYSCLK_F / MIDI_BAUD clocks (1536 at defaults); bit counter SHALL be 11 bits wide, counting 0..CLK_PER_BIT-1.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; MIDI_OUT registered.
REQ-015 IDLE: MIDI_OUT=1; when FIFO non-empty, pop head into shift register, enter START.
REQ-016 START: MIDI_OUT=0 for one bit period, then DATA.
REQ-017 DATA: BYTE_W bits, LSB first, each held one bit period, then STOP.
REQ-018 STOP: MIDI_OUT=1 for one bit period; on its last clock pulse byte_sent_strobe; if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
REQ-019 Latency: byte written on edge N into empty FIFO with FSM IDLE SHALL drive MIDI_OUT low from edge N+2.
REQ-020 wr_en while fifo_full SHALL be ignored (byte dropped, FIFO unchanged), even if a pop occurs on the same edge.
REQ-021 Simultaneous wr_en and pop when not full SHALL both take effect; occupancy unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-023 Frame length SHALL be exactly 10*CLK_PER_BIT clocks from START entry to STOP exit.

Reset
REQ-024 On rst: state IDLE, MIDI_OUT=1, byte_sent_strobe=0, fifo_full=0, busy=0, FIFO empty, counters zero, running-status register cleared.
REQ-025 rst mid-frame SHALL abort the frame; MIDI_OUT high from next edge; queued bytes discarded.

Configuration
REQ-026 Macro MIDI_RUNNING_STATUS_EN: when defined, a popped byte 0x80-0xEF equal to last transmitted status SHALL be discarded in one clock without framing or strobe; 0x80-0xEF transmitted updates the register; 0xF0-0xF7 clears it; 0xF8-0xFF and data bytes 0x00-0x7F leave it unchanged.
REQ-027 Without MIDI_RUNNING_STATUS_EN every queued byte SHALL be transmitted verbatim; no running-status register exists.

Verification
REQ-028 Idle write 0x90 -> MIDI_OUT low at edge N+2; bits 0,0,0,0,1,0,0,1 each 1536 clocks, stop high; byte_sent_strobe once after 15360 clocks.
REQ-029 Burst write 0x90,0x3C,0x7F on consecutive clocks -> three back-to-back frames, no idle gap, three strobes 15360 clocks apart.
REQ-030 Five writes on consecutive clocks while IDLE, FIFO_DEPTH=4 -> fifo_full asserted; overflow byte dropped only if FIFO full at its edge; transmitted sequence matches accepted bytes.
REQ-031 rst asserted during DATA bit 3 -> MIDI_OUT=1 next edge, busy=0, no strobe, pending bytes never sent.
REQ-032 With MIDI_RUNNING_STATUS_EN: queue 0x90,0x3C,0x7F,0x90,0x40,0x7F -> five frames sent, second 0x90 suppressed; queue 0x90,0xF8,0x90 -> 0xF8 sent, second 0x90 suppressed; without macro all six/three sent.
